// File: rtl/joystick_serial_pkg.sv
// Shared types and limits for the serial joystick reader.
package joystick_serial_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift,
      StUpdate
   } state_e;

   localparam int unsigned MAX_JOY      = 4;
   localparam int unsigned MAX_BITS     = 16;
   localparam int unsigned MAX_DEBOUNCE = 15;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/joystick_serial_multi_if.sv
// Bundle of the joystick chain strobes and the decoded button outputs.
interface joystick_serial_multi_if #(
   parameter int unsigned TOTAL = 16
) ();
   logic             enable_i;
   logic             joy_data_i;
   logic             joy_clk_o;
   logic             joy_load_o;
   logic [TOTAL-1:0] joy_o;
   logic             frame_o;
   logic             changed_o;

   // Reader side: drives the chain strobes and the committed buttons.
   modport master (
      input  enable_i, joy_data_i,
      output joy_clk_o, joy_load_o, joy_o, frame_o, changed_o
   );

   // Chain/consumer side.
   modport slave (
      output enable_i, joy_data_i,
      input  joy_clk_o, joy_load_o, joy_o, frame_o, changed_o
   );
endinterface

// File: rtl/joy_tick_gen.sv
// Clock divider producing one tick every CLK_DIV cycles.
module joy_tick_gen
   import joystick_serial_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic hold_i,
   output logic tick_o
);

   localparam int unsigned CW = cnt_width(CLK_DIV);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be at least 1");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

   // Free-running wrap counter; paused for the single-cycle frame update so the
   // tick grid restarts one cycle later and the frame period gains that cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (!hold_i) begin
         cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Divider state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/joystick_serial_multi.sv
// Serial reader for daisy-chained PISO shift registers with frame debounce.
module joystick_serial_multi
   import joystick_serial_pkg::*;
#(
   parameter int unsigned NUM_JOY         = 2,
   parameter int unsigned BITS_PER_JOY    = 8,
   parameter int unsigned CLK_DIV         = 2,
   parameter int unsigned GAP_TICKS       = 2,
   parameter int unsigned DEBOUNCE_FRAMES = 2
) (
   input logic                     clk_i,
   input logic                     rst_i,
   joystick_serial_multi_if.master bus
);

   localparam int unsigned TOTAL = NUM_JOY * BITS_PER_JOY;
   localparam int unsigned BW    = cnt_width(TOTAL);
   localparam int unsigned GW    = cnt_width(GAP_TICKS);

   if (NUM_JOY < 1 || NUM_JOY > MAX_JOY) begin : g_bad_num_joy
      $error("NUM_JOY out of range");
   end
   if (BITS_PER_JOY < 1 || BITS_PER_JOY > MAX_BITS) begin : g_bad_bits
      $error("BITS_PER_JOY out of range");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be at least 1");
   end
   if (GAP_TICKS < 1) begin : g_bad_gap
      $error("GAP_TICKS must be at least 1");
   end
   if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > MAX_DEBOUNCE) begin : g_bad_deb
      $error("DEBOUNCE_FRAMES out of range");
   end

   state_e           state_q, state_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic             load_cnt_q, load_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             phase_q, phase_d;
   logic [TOTAL-1:0] cap_q, cap_d;
   logic [TOTAL-1:0] prev_cap_q, prev_cap_d;
   logic [3:0]       stable_cnt_q, stable_cnt_d;
   logic [TOTAL-1:0] joy_q, joy_d;
   logic             joy_clk_q, joy_clk_d;
   logic             joy_load_q, joy_load_d;
   logic             frame_q, frame_d;
   logic             changed_q, changed_d;

   logic             tick;
   logic             hold;
   logic [BW-1:0]    cap_idx;

   assign hold    = (state_q == StUpdate);
   // First sampled bit lands in the MSB.
   assign cap_idx = BW'(TOTAL - 1) - bit_cnt_q;

   joy_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .hold_i (hold),
      .tick_o (tick)
   );

   // Next-state, strobe generation, capture and debounce.
   always_comb begin
      state_d      = state_q;
      gap_cnt_d    = gap_cnt_q;
      load_cnt_d   = load_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      phase_d      = phase_q;
      cap_d        = cap_q;
      prev_cap_d   = prev_cap_q;
      stable_cnt_d = stable_cnt_q;
      joy_d        = joy_q;
      joy_clk_d    = joy_clk_q;
      joy_load_d   = joy_load_q;
      frame_d      = 1'b0;
      changed_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tick) begin
               if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
                  gap_cnt_d = '0;
                  // Enable is only looked at here, so a frame in flight always completes.
                  if (bus.enable_i) begin
                     state_d    = StLoad;
                     joy_load_d = 1'b0;
                     load_cnt_d = 1'b0;
                  end
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         StLoad: begin
            if (tick) begin
               if (load_cnt_q) begin
                  state_d    = StShift;
                  joy_load_d = 1'b1;
                  bit_cnt_d  = '0;
                  phase_d    = 1'b0;
               end else begin
                  load_cnt_d = 1'b1;
               end
            end
         end
         StShift: begin
            if (tick) begin
               if (!phase_q) begin
                  cap_d[cap_idx] = bus.joy_data_i;
                  joy_clk_d      = 1'b1;
                  phase_d        = 1'b1;
               end else begin
                  joy_clk_d = 1'b0;
                  phase_d   = 1'b0;
                  if (bit_cnt_q == BW'(TOTAL - 1)) begin
                     state_d = StUpdate;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
         end
         StUpdate: begin
            if (cap_q == prev_cap_q) begin
               stable_cnt_d = (stable_cnt_q == 4'(MAX_DEBOUNCE)) ? stable_cnt_q
                                                                  : stable_cnt_q + 1'b1;
            end else begin
               stable_cnt_d = '0;
            end
            prev_cap_d = cap_q;
            if (stable_cnt_d >= 4'(DEBOUNCE_FRAMES - 1)) begin
               joy_d     = cap_q;
               changed_d = (cap_q != joy_q);
            end
            frame_d   = 1'b1;
            gap_cnt_d = '0;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and registered outputs; reset discards any partial frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         gap_cnt_q    <= '0;
         load_cnt_q   <= 1'b0;
         bit_cnt_q    <= '0;
         phase_q      <= 1'b0;
         cap_q        <= '1;
         prev_cap_q   <= '1;
         stable_cnt_q <= '0;
         joy_q        <= '1;
         joy_clk_q    <= 1'b0;
         joy_load_q   <= 1'b1;
         frame_q      <= 1'b0;
         changed_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_cnt_q    <= gap_cnt_d;
         load_cnt_q   <= load_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         phase_q      <= phase_d;
         cap_q        <= cap_d;
         prev_cap_q   <= prev_cap_d;
         stable_cnt_q <= stable_cnt_d;
         joy_q        <= joy_d;
         joy_clk_q    <= joy_clk_d;
         joy_load_q   <= joy_load_d;
         frame_q      <= frame_d;
         changed_q    <= changed_d;
      end
   end

   assign bus.joy_clk_o  = joy_clk_q;
   assign bus.joy_load_o = joy_load_q;
   assign bus.joy_o      = joy_q;
   assign bus.frame_o    = frame_q;
   assign bus.changed_o  = changed_q;

endmodule

// File: tb/tb_joystick_serial_multi.sv
// Bench for joystick_serial_multi: default, waveform and wide-chain instances.
module tb_joystick_serial_multi;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   joystick_serial_multi_if #(.TOTAL(16)) if_d ();
   joystick_serial_multi_if #(.TOTAL(4))  if_w ();
   joystick_serial_multi_if #(.TOTAL(64)) if_e ();

   joystick_serial_multi u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_d)
   );

   joystick_serial_multi #(
      .NUM_JOY         (1),
      .BITS_PER_JOY    (4),
      .CLK_DIV         (3),
      .GAP_TICKS       (2),
      .DEBOUNCE_FRAMES (1)
   ) u_wav (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_w)
   );

   joystick_serial_multi #(
      .NUM_JOY         (4),
      .BITS_PER_JOY    (16),
      .CLK_DIV         (1),
      .GAP_TICKS       (2),
      .DEBOUNCE_FRAMES (1)
   ) u_ext (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (if_e)
   );

   // 74HC165 chain models: parallel load while load is low, shift on joy_clk rise.
   logic [15:0] pat_d = '1, sr_d = '1;
   logic [3:0]  pat_w = '1, sr_w = '1;
   logic [63:0] pat_e = '1, sr_e = '1;
   logic        jc_prev_d = 1'b0, jc_prev_w = 1'b0, jc_prev_e = 1'b0;

   assign if_d.joy_data_i = sr_d[15];
   assign if_w.joy_data_i = sr_w[3];
   assign if_e.joy_data_i = sr_e[63];

   always @(negedge clk) begin
      if (!if_d.joy_load_o) sr_d <= pat_d;
      else if (if_d.joy_clk_o && !jc_prev_d) sr_d <= {sr_d[14:0], 1'b1};
      jc_prev_d <= if_d.joy_clk_o;
   end

   always @(negedge clk) begin
      if (!if_w.joy_load_o) sr_w <= pat_w;
      else if (if_w.joy_clk_o && !jc_prev_w) sr_w <= {sr_w[2:0], 1'b1};
      jc_prev_w <= if_w.joy_clk_o;
   end

   always @(negedge clk) begin
      if (!if_e.joy_load_o) sr_e <= pat_e;
      else if (if_e.joy_clk_o && !jc_prev_e) sr_e <= {sr_e[62:0], 1'b1};
      jc_prev_e <= if_e.joy_clk_o;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Debounce reference model for the default instance and its scoreboard.
   typedef struct packed {
      logic [15:0] joy;
      logic        chg;
   } exp_t;

   exp_t        q_exp[$];
   logic [15:0] m_prev, m_joy;
   int          m_stable;

   task automatic model_reset();
      m_prev   = '1;
      m_joy    = '1;
      m_stable = 0;
   endtask

   task automatic push_frame(input logic [15:0] p);
      exp_t e;
      if (p == m_prev) m_stable = (m_stable < 15) ? m_stable + 1 : 15;
      else m_stable = 0;
      m_prev = p;
      e.chg  = 1'b0;
      if (m_stable >= 1) begin
         e.chg = (p != m_joy);
         m_joy = p;
      end
      e.joy = m_joy;
      q_exp.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && if_d.frame_o) begin
         exp_t e;
         chk("sb_pending", 64'(q_exp.size() != 0), 64'd1);
         if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk("sb_joy", 64'(if_d.joy_o), 64'(e.joy));
            chk("sb_changed", 64'(if_d.changed_o), 64'(e.chg));
         end
      end
   end

   function automatic logic sig(input int id);
      case (id)
         0:       return if_d.frame_o;
         1:       return if_w.frame_o;
         2:       return if_e.frame_o;
         3:       return if_d.joy_load_o;
         4:       return if_w.joy_load_o;
         default: return if_w.joy_clk_o;
      endcase
   endfunction

   // Wait (bounded) until the selected signal reaches lvl; the final compare
   // fails if the bound expired first.
   task automatic wait_level(input int id, input logic lvl, input int limit, input string tag,
                             output int cycles);
      cycles = 0;
      while (sig(id) !== lvl && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
      chk(tag, 64'(sig(id)), 64'(lvl));
   endtask

   // Number of consecutive negedges on which the selected signal stays at lvl.
   task automatic run_len(input int id, input logic lvl, input int limit, output int n);
      n = 0;
      while (sig(id) === lvl && n < limit) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_frame(input logic [15:0] p, output int stamp);
      int c;
      pat_d = p;
      push_frame(p);
      wait_level(0, 1'b1, 300, "d_frame_seen", c);
      stamp = cyc;
      @(negedge clk);
   endtask

   initial begin
      int c, n, s1, s2, s3;
      int walk[4];
      walk[0] = 0; walk[1] = 17; walk[2] = 38; walk[3] = 63;
      if_d.enable_i = 1'b0;
      if_w.enable_i = 1'b0;
      if_e.enable_i = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);

      chk("rst_joy", 64'(if_d.joy_o), 64'hFFFF);
      chk("rst_load", 64'(if_d.joy_load_o), 64'd1);
      chk("rst_clk", 64'(if_d.joy_clk_o), 64'd0);
      chk("rst_frame", 64'(if_d.frame_o), 64'd0);
      chk("rst_changed", 64'(if_d.changed_o), 64'd0);
      chk("rst_ext_joy", if_e.joy_o, 64'hFFFF_FFFF_FFFF_FFFF);
      rst = 1'b0;

      // Waveform instance: CLK_DIV=3, four bits.
      pat_w = 4'b1011;
      if_w.enable_i = 1'b1;
      wait_level(4, 1'b0, 100, "w_load_fall", c);
      run_len(4, 1'b0, 50, n);
      chk("w_load_low", 64'(n), 64'd6);
      run_len(5, 1'b0, 50, n);
      chk("w_first_low", 64'(n), 64'd3);
      for (int i = 0; i < 4; i++) begin
         run_len(5, 1'b1, 50, n);
         chk("w_clk_high", 64'(n), 64'd3);
         if (i < 3) begin
            run_len(5, 1'b0, 50, n);
            chk("w_clk_low", 64'(n), 64'd3);
         end
      end
      if_w.enable_i = 1'b0;
      wait_level(1, 1'b1, 100, "w_frame_seen", c);
      chk("w_joy", 64'(if_w.joy_o), 64'b1011);
      chk("w_changed", 64'(if_w.changed_o), 64'd1);
      @(negedge clk);

      // Wide instance: walking zero across 64 bits, every frame commits.
      pat_e = ~(64'd1 << walk[0]);
      if_e.enable_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_level(2, 1'b1, 400, "e_frame_seen", c);
         chk("e_joy", if_e.joy_o, ~(64'd1 << walk[k]));
         chk("e_changed", 64'(if_e.changed_o), 64'd1);
         if (k < 3) pat_e = ~(64'd1 << walk[k + 1]);
         else if_e.enable_i = 1'b0;
         @(negedge clk);
      end

      // Default instance: two-frame debounce and frame period.
      if_d.enable_i = 1'b1;
      do_frame(16'h7FFE, s1);
      do_frame(16'h7FFE, s2);
      do_frame(16'h7FFE, s3);
      chk("d_period_a", 64'(s2 - s1), 64'd73);
      chk("d_period_b", 64'(s3 - s2), 64'd73);

      // Single-frame glitch must never reach joy_o.
      do_frame(16'hFFFF, s1);
      do_frame(16'hFFFF, s1);
      do_frame(16'hFFFE, s1);
      do_frame(16'hFFFF, s1);
      do_frame(16'hFFFF, s1);
      chk("d_glitch_joy", 64'(if_d.joy_o), 64'hFFFF);

      // Drop enable mid-shift: frame completes, then the reader stays idle.
      pat_d = 16'h7FFE;
      push_frame(16'h7FFE);
      wait_level(3, 1'b0, 200, "d_load_fall", c);
      wait_level(3, 1'b1, 50, "d_load_rise", c);
      repeat (10) @(negedge clk);
      if_d.enable_i = 1'b0;
      wait_level(0, 1'b1, 200, "d_frame_after_disable", c);
      @(negedge clk);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (if_d.joy_load_o === 1'b0) n++;
         @(negedge clk);
      end
      chk("d_no_load_disabled", 64'(n), 64'd0);
      if_d.enable_i = 1'b1;
      wait_level(3, 1'b0, 20, "d_reload", c);
      chk("d_reload_latency", 64'(c >= 1 && c <= 4), 64'd1);
      push_frame(16'h7FFE);
      wait_level(0, 1'b1, 200, "d_frame_reenabled", c);
      @(negedge clk);

      // Asynchronous reset mid-shift, then debounce restarts from zero.
      wait_level(3, 1'b0, 200, "d_load_fall2", c);
      wait_level(3, 1'b1, 50, "d_load_rise2", c);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_joy", 64'(if_d.joy_o), 64'hFFFF);
      chk("mid_rst_load", 64'(if_d.joy_load_o), 64'd1);
      chk("mid_rst_clk", 64'(if_d.joy_clk_o), 64'd0);
      chk("mid_rst_frame", 64'(if_d.frame_o), 64'd0);
      chk("mid_rst_changed", 64'(if_d.changed_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      do_frame(16'h7FFE, s1);
      do_frame(16'h7FFE, s2);
      chk("d_after_rst_joy", 64'(if_d.joy_o), 64'h7FFE);
      if_d.enable_i = 1'b0;

      chk("sb_drained", 64'(q_exp.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
